// File: rtl/riscv_v_mask_chunk_seq.sv
// riscv_v_mask_chunk_seq
//   Fetches one vector mask register per instruction and streams per-element
//   enable chunks to the lane datapath. vstart, vl (clamped to VLEN) and the
//   vm (unmasked) bit are folded in here, so lanes receive final enables.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   instruction request handshake (ready only in IDLE)
//   req_vm                1 = unmasked, the mask register is not read
//   req_mask_addr         mask register to fetch
//   req_vstart, req_vl    first active element, vector length
//   rf_rd_addr            mask RF read address (registered)
//   rf_rd_data            mask RF read data, RF_RD_LAT cycles after address
//   out_valid/out_ready   enable beat handshake
//   out_en                element enables, bit i = element out_idx+i
//   out_idx               base element index of the beat
//   out_last              final beat of the instruction
//   busy                  sequencer is not idle
module riscv_v_mask_chunk_seq #(
  parameter int VLEN      = 128,
  parameter int CHUNK_W   = 8,
  parameter int RF_RD_LAT = 0,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = $clog2(VLEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_vm,
  input  logic [ADDR_W-1:0] req_mask_addr,
  input  logic [CNT_W-1:0]  req_vstart,
  input  logic [CNT_W-1:0]  req_vl,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [VLEN-1:0]   rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHUNK_W-1:0] out_en,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(VLEN);
  localparam logic [CNT_W-1:0] VLEN_C     = CNT_W'(VLEN);
  localparam logic [CNT_W-1:0] CHUNK_C    = CNT_W'(CHUNK_W);
  localparam logic [1:0]       FETCH_LAST = 2'(RF_RD_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Enables for one beat starting at element 'base'.
  function automatic logic [CHUNK_W-1:0] beat_en(
    input logic [CNT_W-1:0] base,
    input logic [CNT_W-1:0] vstart,
    input logic [CNT_W-1:0] vl,
    input logic             vm,
    input logic [VLEN-1:0]  mask
  );
    logic [CHUNK_W-1:0] en;
    logic [CNT_W-1:0]   e;
    en = {CHUNK_W{1'b0}};
    for (int i = 0; i < CHUNK_W; i++) begin
      e = base + CNT_W'(i);
      // e < vl <= VLEN guards the truncated mask index
      en[i] = (e >= vstart) && (e < vl) && (vm || mask[e[IDX_W-1:0]]);
    end
    return en;
  endfunction

  // A beat is last when the next base would reach or pass vl.
  function automatic logic beat_last(
    input logic [CNT_W-1:0] base,
    input logic [CNT_W-1:0] vl
  );
    logic [CNT_W:0] nxt;
    nxt = {1'b0, base} + {1'b0, CHUNK_C};
    return nxt >= {1'b0, vl};
  endfunction

  state_t              state_r, next_state_s;
  logic                vm_r;
  logic [CNT_W-1:0]    vstart_r, vl_r, base_r;
  logic [VLEN-1:0]     mask_r;
  logic [1:0]          fetch_cnt_r;
  logic [ADDR_W-1:0]   rf_rd_addr_r;
  logic                out_valid_r, out_last_r, busy_r, req_ready_r;
  logic [CHUNK_W-1:0]  out_en_r;
  logic [CNT_W-1:0]    out_idx_r;

  logic [CNT_W-1:0]    vl_eff_s, base_init_s;
  logic                accept_s, req_empty_s, xfer_s, fetch_done_s;
  logic                load_beat_s, beat_vm_s, beat_last_s;
  logic [CNT_W-1:0]    beat_base_s, beat_vstart_s, beat_vl_s;
  logic [VLEN-1:0]     beat_mask_s;
  logic [CHUNK_W-1:0]  beat_en_s;

  assign vl_eff_s     = (req_vl > VLEN_C) ? VLEN_C : req_vl;
  assign base_init_s  = req_vstart - (req_vstart % CHUNK_C);
  assign accept_s     = req_valid && (state_r == IDLE);
  assign req_empty_s  = (req_vstart >= vl_eff_s);
  assign xfer_s       = out_valid_r && out_ready;
  assign fetch_done_s = (state_r == FETCH) && (fetch_cnt_r == FETCH_LAST);

  // Next state and selection of the beat to present on the next cycle.
  // The first masked beat is built straight from rf_rd_data so it can be
  // registered on the same edge that captures the mask buffer.
  always_comb begin
    next_state_s  = state_r;
    load_beat_s   = 1'b0;
    beat_base_s   = base_r;
    beat_vstart_s = vstart_r;
    beat_vl_s     = vl_r;
    beat_vm_s     = vm_r;
    beat_mask_s   = mask_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !req_empty_s) begin
          if (req_vm) begin
            next_state_s  = STREAM;
            load_beat_s   = 1'b1;
            beat_base_s   = base_init_s;
            beat_vstart_s = req_vstart;
            beat_vl_s     = vl_eff_s;
            beat_vm_s     = 1'b1;
          end else begin
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_done_s) begin
          next_state_s = STREAM;
          load_beat_s  = 1'b1;
          beat_mask_s  = rf_rd_data;
        end else begin
          next_state_s = FETCH;
        end
      end
      STREAM: begin
        if (xfer_s) begin
          if (out_last_r) begin
            next_state_s = IDLE;
          end else begin
            load_beat_s = 1'b1;
            beat_base_s = base_r + CHUNK_C;
          end
        end else begin
          next_state_s = STREAM;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign beat_en_s   = beat_en(beat_base_s, beat_vstart_s, beat_vl_s, beat_vm_s, beat_mask_s);
  assign beat_last_s = beat_last(beat_base_s, beat_vl_s);

  // State register plus registered status decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != IDLE);
      req_ready_r <= (next_state_s == IDLE);
    end
  end

  // Request latches, beat base, fetch counter and mask buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vm_r         <= 1'b0;
      vstart_r     <= {CNT_W{1'b0}};
      vl_r         <= {CNT_W{1'b0}};
      base_r       <= {CNT_W{1'b0}};
      fetch_cnt_r  <= 2'd0;
      rf_rd_addr_r <= {ADDR_W{1'b0}};
      mask_r       <= {VLEN{1'b0}};
    end else if (accept_s) begin
      vm_r         <= req_vm;
      vstart_r     <= req_vstart;
      vl_r         <= vl_eff_s;
      base_r       <= base_init_s;
      fetch_cnt_r  <= 2'd0;
      rf_rd_addr_r <= req_mask_addr;
    end else begin
      if (load_beat_s) begin
        base_r <= beat_base_s;
      end
      if (state_r == FETCH) begin
        fetch_cnt_r <= fetch_cnt_r + 2'd1;
      end
      if (fetch_done_s) begin
        mask_r <= rf_rd_data;
      end
    end
  end

  // Output beat register: loads a new beat, drops valid after the last
  // transfer, and holds everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_en_r    <= {CHUNK_W{1'b0}};
      out_idx_r   <= {CNT_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (load_beat_s) begin
      out_valid_r <= 1'b1;
      out_en_r    <= beat_en_s;
      out_idx_r   <= beat_base_s;
      out_last_r  <= beat_last_s;
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign rf_rd_addr = rf_rd_addr_r;
  assign out_valid  = out_valid_r;
  assign out_en     = out_en_r;
  assign out_idx    = out_idx_r;
  assign out_last   = out_last_r;

endmodule

// File: tb/tb_riscv_v_mask_chunk_seq.sv
// Bench for riscv_v_mask_chunk_seq: two instances (async RF and one-cycle
// registered RF) share stimulus; a reference model pushes expected beats into
// per-instance queues and a monitor pops them on every transfer.
module tb_riscv_v_mask_chunk_seq;
  localparam int VLEN    = 128;
  localparam int CHUNK_W = 8;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 8;

  typedef struct {
    logic [CHUNK_W-1:0] en;
    logic [CNT_W-1:0]   idx;
    logic               last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req_valid;
  logic              req_vm;
  logic [ADDR_W-1:0] req_mask_addr;
  logic [CNT_W-1:0]  req_vstart;
  logic [CNT_W-1:0]  req_vl;
  logic              rand_mode, ready_force, rand_ready;
  logic              out_ready;

  logic [1:0]                req_ready, out_valid, out_last, busy;
  logic [1:0][CHUNK_W-1:0]   out_en;
  logic [1:0][CNT_W-1:0]     out_idx;
  logic [1:0][ADDR_W-1:0]    rf_rd_addr;
  logic [VLEN-1:0]           rf_data0, rf_data1;

  logic [VLEN-1:0] mem [32];

  assign out_ready = rand_mode ? rand_ready : ready_force;
  assign rf_data0  = mem[rf_rd_addr[0]];
  always @(posedge clk) rf_data1 <= mem[rf_rd_addr[1]];
  always @(posedge clk) begin
    #1;
    rand_ready = ($urandom_range(3) != 0);
  end

  riscv_v_mask_chunk_seq #(.VLEN(VLEN), .CHUNK_W(CHUNK_W), .RF_RD_LAT(0), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_vm(req_vm), .req_mask_addr(req_mask_addr), .req_vstart(req_vstart), .req_vl(req_vl),
    .rf_rd_addr(rf_rd_addr[0]), .rf_rd_data(rf_data0), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_en(out_en[0]), .out_idx(out_idx[0]), .out_last(out_last[0]),
    .busy(busy[0]));

  riscv_v_mask_chunk_seq #(.VLEN(VLEN), .CHUNK_W(CHUNK_W), .RF_RD_LAT(1), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_vm(req_vm), .req_mask_addr(req_mask_addr), .req_vstart(req_vstart), .req_vl(req_vl),
    .rf_rd_addr(rf_rd_addr[1]), .rf_rd_data(rf_data1), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_en(out_en[1]), .out_idx(out_idx[1]), .out_last(out_last[1]),
    .busy(busy[1]));

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q [2][$];
  int    xfer_cnt [2];
  int    last_idx [2];
  logic [1:0] stalled;
  logic [1:0][CHUNK_W+CNT_W:0] held;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: walk chunk bases from floor(vstart) up to vl_eff.
  task automatic push_expected(input logic vm, input int addr, input int vstart, input int vl);
    int    vl_eff;
    beat_t b;
    vl_eff = (vl > VLEN) ? VLEN : vl;
    if (vstart >= vl_eff) return;
    for (int base = (vstart / CHUNK_W) * CHUNK_W; base < vl_eff; base += CHUNK_W) begin
      for (int i = 0; i < CHUNK_W; i++) begin
        int e;
        e = base + i;
        b.en[i] = (e >= vstart) && (e < vl_eff) && (vm || mem[addr][e]);
      end
      b.idx  = base[CNT_W-1:0];
      b.last = (base + CHUNK_W >= vl_eff);
      exp_q[0].push_back(b);
      exp_q[1].push_back(b);
    end
  endtask

  // Monitor: compare every transferred beat and check stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (stalled[d] && out_valid[d])
          chk("hold", d, {out_last[d], out_idx[d], out_en[d]}, held[d]);
        if (out_valid[d] && out_ready) begin
          xfer_cnt[d]++;
          if (out_last[d]) last_idx[d] = out_idx[d];
          if (exp_q[d].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat dut%0d: got idx %0d, expected no beat", d, out_idx[d]);
          end else begin
            beat_t e;
            e = exp_q[d].pop_front();
            chk("beat_en", d, out_en[d], e.en);
            chk("beat_idx", d, out_idx[d], e.idx);
            chk("beat_last", d, out_last[d], e.last);
          end
          stalled[d] = 1'b0;
        end else if (out_valid[d]) begin
          stalled[d] = 1'b1;
          held[d]    = {out_last[d], out_idx[d], out_en[d]};
        end else begin
          stalled[d] = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drives a request for one cycle (cycle 0); returns at the start of cycle 1.
  task automatic issue(input logic vm, input int addr, input int vstart, input int vl);
    next_cycle();
    req_valid     = 1'b1;
    req_vm        = vm;
    req_mask_addr = addr[ADDR_W-1:0];
    req_vstart    = vstart[CNT_W-1:0];
    req_vl        = vl[CNT_W-1:0];
    push_expected(vm, addr, vstart, vl);
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      sample();
      if (req_ready == 2'b11) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: req_ready %b, expected 11 within 3000 cycles", req_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0, c1;
    bit  found;
    rst_n = 1'b0; req_valid = 1'b0; req_vm = 1'b0; req_mask_addr = '0;
    req_vstart = '0; req_vl = '0; rand_mode = 1'b0; ready_force = 1'b1; rand_ready = 1'b1;
    xfer_cnt[0] = 0; xfer_cnt[1] = 0; last_idx[0] = 0; last_idx[1] = 0;
    stalled = 2'b00; held = '0;
    for (int a = 0; a < 32; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    mem[0][7:0]  = 8'hA5;
    mem[7][7:0]  = 8'h3C;
    mem[31]      = {VLEN{1'b1}};

    // reset values
    repeat (3) sample();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, req_ready[d], 1);
      chk("rst_out_valid", d, out_valid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_rf_addr", d, rf_rd_addr[d], 0);
      chk("rst_out_en", d, out_en[d], 0);
      chk("rst_out_idx", d, out_idx[d], 0);
      chk("rst_out_last", d, out_last[d], 0);
    end
    next_cycle();
    rst_n = 1'b1;

    // warm-up so the registered RF holds a different address's data
    issue(1'b0, 7, 0, 8);
    wait_idle();

    // basic masked fetch (dut0) and registered-RF timing (dut1)
    issue(1'b0, 0, 0, 8);
    sample();
    chk("c1_rf_addr", 0, rf_rd_addr[0], 0);
    chk("c1_valid", 0, out_valid[0], 0);
    chk("c1_valid", 1, out_valid[1], 0);
    next_cycle(); sample();
    chk("c2_valid", 0, out_valid[0], 1);
    chk("c2_en", 0, out_en[0], 8'hA5);
    chk("c2_idx", 0, out_idx[0], 0);
    chk("c2_last", 0, out_last[0], 1);
    chk("c2_valid", 1, out_valid[1], 0);
    next_cycle(); sample();
    chk("c3_req_ready", 0, req_ready[0], 1);
    chk("c3_valid", 0, out_valid[0], 0);
    chk("c3_valid", 1, out_valid[1], 1);
    chk("c3_en", 1, out_en[1], 8'hA5);
    wait_idle();

    // unmasked with vstart
    issue(1'b1, 0, 3, 13);
    sample();
    chk("vm_c1_valid", 0, out_valid[0], 1);
    chk("vm_c1_en", 0, out_en[0], 8'hF8);
    chk("vm_c1_idx", 0, out_idx[0], 0);
    chk("vm_c1_last", 0, out_last[0], 0);
    chk("vm_c1_rf_addr", 0, rf_rd_addr[0], 0);
    chk("vm_c1_valid", 1, out_valid[1], 1);
    next_cycle(); sample();
    chk("vm_c2_en", 0, out_en[0], 8'h1F);
    chk("vm_c2_idx", 0, out_idx[0], 8);
    chk("vm_c2_last", 0, out_last[0], 1);
    next_cycle(); sample();
    chk("vm_c3_valid", 0, out_valid[0], 0);
    wait_idle();

    // backpressure on the single beat
    c0 = xfer_cnt[0];
    issue(1'b0, 0, 0, 8);
    ready_force = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      next_cycle();
      if (k == 5) ready_force = 1'b1;
      sample();
      chk("bp_valid", 0, out_valid[0], 1);
      chk("bp_en", 0, out_en[0], 8'hA5);
    end
    next_cycle(); sample();
    chk("bp_done_valid", 0, out_valid[0], 0);
    wait_idle();
    chk("bp_beats", 0, xfer_cnt[0] - c0, 1);

    // empty request
    issue(1'b0, 0, 10, 10);
    sample();
    chk("empty_req_ready", 0, req_ready[0], 1);
    chk("empty_req_ready", 1, req_ready[1], 1);
    chk("empty_valid", 0, out_valid[0], 0);
    chk("empty_busy", 0, busy[0], 0);
    next_cycle(); sample();
    chk("empty_valid_c2", 0, out_valid[0], 0);

    // vl clamp to VLEN
    c0 = xfer_cnt[0]; c1 = xfer_cnt[1];
    issue(1'b0, 31, 0, 200);
    wait_idle();
    chk("clamp_beats", 0, xfer_cnt[0] - c0, 16);
    chk("clamp_beats", 1, xfer_cnt[1] - c1, 16);
    chk("clamp_last_idx", 0, last_idx[0], 120);
    chk("clamp_last_idx", 1, last_idx[1], 120);

    // reset while the idx=8 beat is valid
    issue(1'b0, 31, 0, 200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      sample();
      if (out_valid[0] && out_idx[0] == 8) found = 1'b1;
    end
    chk("rst_hit_idx8", 0, found, 1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_valid", d, out_valid[d], 0);
      chk("midrst_busy", d, busy[d], 0);
    end
    exp_q[0].delete();
    exp_q[1].delete();
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    sample();
    chk("post_rst_req_ready", 0, req_ready[0], 1);
    c0 = xfer_cnt[0];
    issue(1'b0, 0, 0, 8);
    wait_idle();
    chk("post_rst_beats", 0, xfer_cnt[0] - c0, 1);

    // randomized requests with random backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int vs, vl, ad;
      logic vm;
      wait_idle();
      mem[$urandom_range(31)] = {$urandom, $urandom, $urandom, $urandom};
      vm = ($urandom_range(3) == 0);
      ad = $urandom_range(31);
      vl = $urandom_range(0, 200);
      vs = ($urandom_range(1) == 0) ? 0 : $urandom_range(0, 140);
      issue(vm, ad, vs, vl);
    end
    wait_idle();
    rand_mode = 1'b0;
    repeat (2) sample();
    chk("final_queue_empty", 0, exp_q[0].size(), 0);
    chk("final_queue_empty", 1, exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
